// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet constants and receive FSM state encoding
package eth_pkg;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_DROP = 3'd3;
    localparam logic [2:0] ST_EOF  = 3'd4;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_FRAME   = 11'd64;
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: byte-wide reflected CRC-32 next-state
// Ports: crc current register, d input byte, nxt register after absorbing d
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  d,
    output logic [31:0] nxt
);
    always_comb begin
        nxt = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) nxt = nxt[0] ? (nxt >> 1) ^ CRC_POLY : nxt >> 1;
    end
endmodule

// File: rtl/eth_frame_rx.sv
// eth_frame_rx: GMII receive frame parser; strips preamble/SFD and FCS, checks CRC-32
// Ports: gmii_rxc clock, rst_n sync active-low reset, gmii_rxdv/rxd/rxer GMII input,
//        rx_data/rx_valid/rx_sof payload stream, rx_eof strobe with rx_good/rx_err/rx_len
module eth_frame_rx
    import eth_pkg::*;
#(
    parameter int MAX_FRAME = 1518,
    parameter bit CHECK_CRC = 1'b1,
    parameter int LEN_W     = 11
) (
    input  logic             gmii_rxc,
    input  logic             rst_n,
    input  logic             gmii_rxdv,
    input  logic [7:0]       gmii_rxd,
    input  logic             gmii_rxer,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic             rx_good,
    output logic [3:0]       rx_err,
    output logic [LEN_W-1:0] rx_len
);
    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);
    logic             r_dv, r_er;
    logic [7:0]       r_d, s0, s1, s2, s3;
    logic [2:0]       st;
    logic [10:0]      cnt;
    logic [31:0]      crc, crc_nxt;
    logic             phy_er, ovs;
    logic [3:0]       err_v;
    eth_crc32_d8 u_crc (.crc(crc), .d(r_d), .nxt(crc_nxt));
    // a truncated frame never delivers its FCS, so its CRC bit is meaningless
    assign err_v = {phy_er, ovs, cnt < MIN_FRAME, CHECK_CRC && !ovs && crc != CRC_RESIDUE};
    always_ff @(posedge gmii_rxc) begin
        if (!rst_n) begin
            {r_dv, r_er, r_d} <= '0;
            {s0, s1, s2, s3} <= '0;
            st <= ST_IDLE;
            cnt <= '0;
            crc <= CRC_INIT;
            {phy_er, ovs} <= '0;
            {rx_data, rx_valid, rx_sof, rx_eof, rx_good, rx_err, rx_len} <= '0;
        end else begin
            r_dv <= gmii_rxdv;
            r_d <= gmii_rxd;
            r_er <= gmii_rxer;
            {rx_valid, rx_sof, rx_eof, rx_good, rx_err, rx_len} <= '0;
            case (st)
                ST_IDLE: begin
                    cnt <= '0;
                    crc <= CRC_INIT;
                    {phy_er, ovs} <= '0;
                    if (r_dv) st <= r_d == PREAMBLE_BYTE ? ST_PRE : r_d == SFD_BYTE ? ST_DATA : ST_DROP;
                end
                ST_PRE: st <= !r_dv ? ST_IDLE : r_er ? ST_DROP : r_d == SFD_BYTE ? ST_DATA :
                              r_d == PREAMBLE_BYTE ? ST_PRE : ST_DROP;
                ST_DATA: begin
                    if (!r_dv) st <= cnt > 11'd4 ? ST_EOF : ST_IDLE;
                    else if (cnt == MAX_CNT) begin
                        ovs <= 1'b1;
                        st <= ST_DROP;
                    end else begin
                        cnt <= cnt + {10'd0, cnt != '1};
                        crc <= crc_nxt;
                        phy_er <= phy_er | r_er;
                        // a byte leaves the line only once four newer bytes exist, so FCS never escapes
                        {s3, s2, s1, s0} <= {s2, s1, s0, r_d};
                        rx_data <= s3;
                        rx_valid <= cnt >= 11'd4;
                        rx_sof <= cnt == 11'd4;
                    end
                end
                ST_DROP: if (!r_dv) st <= cnt > 11'd4 ? ST_EOF : ST_IDLE;
                ST_EOF: begin
                    rx_eof <= 1'b1;
                    rx_err <= err_v;
                    rx_good <= err_v == 4'd0;
                    rx_len <= LEN_W'(cnt - 11'd4);
                    st <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule
